voq_slot_scheduler: RTL

- Per-time-slot crossbar scheduler for the fixed-length N×N packet switch.
- Each slot, it runs a single-iteration iSLIP match (grant then accept, round-robin) over the virtual-output-queue request matrix.
- It drives the crossbar configuration and pulses VOQ dequeues.
- It runs only while the software control block asserts experimenting; it sits between the ingress VOQs and the crossbar/egress datapath.

---
 rtl/switch_pkg.sv | 14 +
 rtl/voq_slot_scheduler_rr_arbiter.sv | 26 ++
 rtl/voq_slot_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared constants and types for the N x N slot-scheduled packet switch
package switch_pkg;
  localparam int N_PORT = 4;
  localparam int SLOT_CYCLES = 16;
  localparam int SEL_W = $clog2(N_PORT);
  typedef logic [SEL_W-1:0] port_idx_t;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_ACCEPT   = 3'd2,
    S_ISSUE    = 3'd3,
    S_TRANSFER = 3'd4
  } sched_state_t;
endpackage

// File: rtl/voq_slot_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req   in  N  request vector
//   ptr   in  W  highest-priority index
//   gnt   out N  one-hot grant (zero when no request)
//   valid out 1  any request present
module rr_arbiter #(
  parameter int N = switch_pkg::N_PORT,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic         valid
);
  logic [W-1:0] idx;
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) gnt = N'(1) << idx;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/voq_slot_scheduler.sv
// voq_slot_scheduler: per-slot single-iteration iSLIP crossbar scheduler
//   clk, reset (sync, active-low)
//   experimenting in  enable; a started slot always runs to completion
//   voq_req       in  bit i*N_PORT+j = VOQ(i->j) non-empty, sampled in GRANT
//   sched_valid   out one-cycle pulse when a slot configuration is applied
//   voq_deq       out one-cycle dequeue per matched (i,j), with sched_valid
//   xbar_en       out bit j = output j carries a packet this slot
//   xbar_sel      out field j = input feeding output j
//   slot_active   out high from ISSUE through the end of TRANSFER
module voq_slot_scheduler #(
  parameter int N_PORT = switch_pkg::N_PORT,
  parameter int SLOT_CYCLES = switch_pkg::SLOT_CYCLES,
  parameter int SEL_W = $clog2(N_PORT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      experimenting,
  input  logic [N_PORT*N_PORT-1:0]  voq_req,
  output logic                      sched_valid,
  output logic [N_PORT*N_PORT-1:0]  voq_deq,
  output logic [N_PORT-1:0]         xbar_en,
  output logic [N_PORT*SEL_W-1:0]   xbar_sel,
  output logic                      slot_active
);
  import switch_pkg::*;
  localparam int CNT_W = $clog2(SLOT_CYCLES);
  sched_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [N_PORT-1:0] out_req [N_PORT];
  logic [N_PORT-1:0] out_gnt [N_PORT];
  logic [N_PORT-1:0] gnt_q [N_PORT];
  logic [N_PORT-1:0] in_req [N_PORT];
  logic [N_PORT-1:0] in_acc [N_PORT];
  logic [N_PORT-1:0] gnt_any;
  logic [N_PORT-1:0] acc_any;
  logic [SEL_W-1:0] grant_ptr [N_PORT];
  logic [SEL_W-1:0] accept_ptr [N_PORT];
  logic [N_PORT-1:0] match_en;
  logic [N_PORT*SEL_W-1:0] match_sel;
  logic [N_PORT*N_PORT-1:0] match_deq;
  // out_req[j] lists inputs requesting output j; in_req[i] lists outputs granting input i.
  for (genvar i = 0; i < N_PORT; i++) begin : g_row
    for (genvar j = 0; j < N_PORT; j++) begin : g_col
      assign out_req[j][i] = voq_req[i*N_PORT+j];
      assign in_req[i][j] = gnt_q[j][i];
    end
  end
  for (genvar g = 0; g < N_PORT; g++) begin : g_arb
    rr_arbiter #(.N(N_PORT), .W(SEL_W)) u_grant (
      .req(out_req[g]), .ptr(grant_ptr[g]), .gnt(out_gnt[g]), .valid(gnt_any[g])
    );
    rr_arbiter #(.N(N_PORT), .W(SEL_W)) u_accept (
      .req(in_req[g]), .ptr(accept_ptr[g]), .gnt(in_acc[g]), .valid(acc_any[g])
    );
  end
  // Each input accepts at most one output and each output grants at most one
  // input, so the accepted set is a partial permutation by construction.
  always_comb begin
    match_en = '0;
    match_sel = '0;
    match_deq = '0;
    for (int i = 0; i < N_PORT; i++)
      for (int j = 0; j < N_PORT; j++)
        if (acc_any[i] && in_acc[i][j]) begin
          match_en[j] = 1'b1;
          match_sel[j*SEL_W +: SEL_W] = SEL_W'(i);
          match_deq[i*N_PORT+j] = 1'b1;
        end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      sched_valid <= 1'b0;
      voq_deq <= '0;
      xbar_en <= '0;
      xbar_sel <= '0;
      slot_active <= 1'b0;
      for (int k = 0; k < N_PORT; k++) begin
        grant_ptr[k] <= '0;
        accept_ptr[k] <= '0;
        gnt_q[k] <= '0;
      end
    end else begin
      sched_valid <= 1'b0;
      voq_deq <= '0;
      case (state)
        S_IDLE: state <= experimenting ? S_GRANT : S_IDLE;
        S_GRANT: begin
          for (int j = 0; j < N_PORT; j++) gnt_q[j] <= gnt_any[j] ? out_gnt[j] : '0;
          state <= S_ACCEPT;
        end
        S_ACCEPT: begin
          // Only accepted pairs advance pointers; this is what desynchronises them.
          for (int i = 0; i < N_PORT; i++)
            for (int j = 0; j < N_PORT; j++)
              if (acc_any[i] && in_acc[i][j]) begin
                grant_ptr[j] <= SEL_W'((i + 1) % N_PORT);
                accept_ptr[i] <= SEL_W'((j + 1) % N_PORT);
              end
          sched_valid <= 1'b1;
          voq_deq <= match_deq;
          xbar_en <= match_en;
          xbar_sel <= match_sel;
          slot_active <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt <= '0;
          state <= S_TRANSFER;
        end
        S_TRANSFER: begin
          if (cnt == CNT_W'(SLOT_CYCLES - 4)) begin
            slot_active <= 1'b0;
            state <= experimenting ? S_GRANT : S_IDLE;
            xbar_en <= experimenting ? xbar_en : '0;
            xbar_sel <= experimenting ? xbar_sel : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
